// File: rtl/rst_seq_ctrl_if.sv
// rst_seq_ctrl_if: request inputs and sequenced clock/reset outputs of rst_seq_ctrl
interface rst_seq_ctrl_if #(
  parameter int NUM_DOMAINS = 4,
  parameter int CNT_W = 16
);
  logic start_i;
  logic stop_i;
  logic rst_req_i;
  logic [CNT_W-1:0] stage_cycles_i;
  logic clk_en_o;
  logic [NUM_DOMAINS-1:0] dom_rst_n_o;
  logic [2:0] stage_o;
  logic busy_o;
  logic done_o;
  modport master (
    output start_i, stop_i, rst_req_i, stage_cycles_i,
    input clk_en_o, dom_rst_n_o, stage_o, busy_o, done_o
  );
  modport slave (
    input start_i, stop_i, rst_req_i, stage_cycles_i,
    output clk_en_o, dom_rst_n_o, stage_o, busy_o, done_o
  );
endinterface

// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: clock-enable then staged, in-order release of NUM_DOMAINS active-low resets
module rst_seq_ctrl #(
  parameter int NUM_DOMAINS = 4,
  parameter int CNT_W = 16,
  parameter int CLK_SETTLE_CYC = 8
) (
  input logic clk_i,
  input logic rst_n_i,
  rst_seq_ctrl_if.slave bus
);
  localparam logic [2:0] IDLE = 3'd0, CLK_ON = 3'd1, RELEASE = 3'd2, DONE = 3'd3, ASSERT = 3'd4, STOP = 3'd5;
  logic [2:0] state, n_state, stage, n_stage;
  logic [CNT_W-1:0] cnt, n_cnt, d;
  logic [NUM_DOMAINS-1:0] dom, n_dom;
  logic clk_en, n_clk_en, busy, done, last, last_stage, go_assert;
  assign d = bus.stage_cycles_i == '0 ? CNT_W'(1) : bus.stage_cycles_i;
  assign last = cnt == CNT_W'(1);
  assign last_stage = stage == 3'(NUM_DOMAINS - 1);
  assign go_assert = bus.rst_req_i && (state inside {CLK_ON, RELEASE, DONE, ASSERT});
  always_comb begin
    n_state = state;
    n_stage = stage;
    n_cnt = cnt == '0 ? cnt : cnt - CNT_W'(1);
    n_dom = dom;
    n_clk_en = clk_en;
    case (state)
      IDLE: if (bus.start_i) begin
        n_state = CLK_ON;
        n_clk_en = 1'b1;
        n_cnt = CNT_W'(CLK_SETTLE_CYC);
        n_stage = '0;
      end
      CLK_ON, ASSERT: if (last) begin
        n_state = RELEASE;
        n_stage = '0;
        n_cnt = d;
      end
      RELEASE: if (last) begin
        n_dom = dom | (NUM_DOMAINS'(1) << stage);
        n_state = last_stage ? DONE : RELEASE;
        n_stage = last_stage ? stage : stage + 3'd1;
        n_cnt = d;
      end
      DONE: if (bus.stop_i) begin
        n_state = STOP;
        n_dom = '0;
        n_cnt = CNT_W'(2);
      end
      STOP: if (last) begin
        n_state = IDLE;
        n_clk_en = 1'b0;
        n_stage = '0;
      end
      default: n_state = IDLE;
    endcase
    // re-reset outranks stop and any pending stage completion
    if (go_assert) begin
      n_state = ASSERT;
      n_dom = '0;
      n_cnt = d;
      n_stage = '0;
      n_clk_en = 1'b1;
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
      stage <= '0;
      cnt <= '0;
      dom <= '0;
      clk_en <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= n_state;
      stage <= n_stage;
      cnt <= n_cnt;
      dom <= n_dom;
      clk_en <= n_clk_en;
      busy <= n_state inside {CLK_ON, RELEASE, ASSERT, STOP};
      done <= n_state == DONE;
    end
  end
  assign bus.clk_en_o = clk_en;
  assign bus.dom_rst_n_o = dom;
  assign bus.stage_o = stage;
  assign bus.busy_o = busy;
  assign bus.done_o = done;
endmodule

// File: doc/rst_seq_ctrl.md
RST_SEQ_CTRL -- requirements
Module: rst_seq_ctrl

Interface
REQ-001 Parameter NUM_DOMAINS, default 4: number of sequenced reset domains (range 1..8).
REQ-002 Parameter CNT_W, default 16: width of the stage-delay counter.
REQ-003 Parameter CLK_SETTLE_CYC, default 8: cycles clk_en_o is high before the first stage delay starts (range 1..2^CNT_W-1).
REQ-004 Port clk_i  input  1: single clock; all state changes on its rising edge.
REQ-005 Port rst_n_i  input  1: reset, synchronous and active-low.
REQ-006 Port start_i  input  1: level; requests power-up sequence from IDLE.
REQ-007 Port stop_i  input  1: level; requests shutdown from DONE.
REQ-008 Port rst_req_i  input  1: level; requests re-reset of all domains from any non-IDLE state.
REQ-009 Port stage_cycles_i  input  CNT_W: per-stage release delay D in cycles; 0 is treated as 1.
REQ-010 Port clk_en_o  output  1: gate enable for the downstream clock generator.
REQ-011 Port dom_rst_n_o  output  NUM_DOMAINS: active-low domain resets, released in index order 0 first.
REQ-012 Port stage_o  output  3: index of the domain currently being timed.
REQ-013 Port busy_o  output  1: high in CLK_ON, RELEASE, ASSERT and STOP.
REQ-014 Port done_o  output  1: high only in DONE.

Function
REQ-015 States SHALL be IDLE, CLK_ON, RELEASE, DONE, ASSERT, STOP; all outputs are registered.
REQ-016 Request priority SHALL be rst_req_i > stop_i > start_i when several are high in the same cycle.
REQ-017 IDLE: clk_en_o=0, dom_rst_n_o all 0; start_i high -> CLK_ON on the next edge; rst_req_i and stop_i ignored.
REQ-018 CLK_ON: clk_en_o=1 from the entering edge; after exactly CLK_SETTLE_CYC cycles -> RELEASE with stage_o=0.
REQ-019 RELEASE: on entry to each stage, D SHALL be sampled from stage_cycles_i once; later changes to the input do not affect the running stage.
REQ-020 RELEASE: dom_rst_n_o[stage_o] SHALL rise exactly D cycles after stage entry; the same edge enters the next stage (stage_o+1), or enters DONE if stage_o=NUM_DOMAINS-1.
REQ-021 Released domains SHALL stay released (1) until ASSERT, STOP or rst_n_i.
REQ-022 DONE: clk_en_o=1, dom_rst_n_o all 1, stage_o=NUM_DOMAINS-1; stop_i -> STOP; rst_req_i -> ASSERT.
REQ-023 ASSERT: entered on the edge after rst_req_i is sampled in CLK_ON, RELEASE or DONE; all dom_rst_n_o=0 on that edge; clk_en_o stays 1; D is sampled; after D cycles -> RELEASE with stage_o=0. No CLK_SETTLE_CYC wait applies.
REQ-024 rst_req_i sampled high while in ASSERT SHALL restart the ASSERT hold count with a fresh D.
REQ-025 stop_i SHALL be honoured only in DONE; it is ignored in other states.
REQ-026 STOP: all dom_rst_n_o=0 on the entering edge; clk_en_o=1 for exactly 2 cycles; then clk_en_o=0 and the next state is IDLE.
REQ-027 rst_req_i sampled in STOP SHALL be ignored; STOP always completes to IDLE.
REQ-028 The counter SHALL decrement by one per cycle and never wrap.
REQ-029 stage_cycles_i=2^CNT_W-1 SHALL give exactly 2^CNT_W-1 cycles.

Reset
REQ-030 rst_n_i low at a rising edge SHALL force IDLE in any state, including mid-RELEASE, ASSERT or STOP.
REQ-031 Outputs after reset SHALL be: clk_en_o=0, dom_rst_n_o all 0, stage_o=0, busy_o=0, done_o=0.
REQ-032 The counter SHALL clear on reset; rst_n_i takes priority over every request input.

Verification
REQ-033 Power-up: reset, then start_i=1, stage_cycles_i=5, defaults. Required: clk_en_o rises at edge E; dom_rst_n_o[0] at E+13; [1] at E+18; [2] at E+23; [3] at E+28; done_o=1 at E+28.
REQ-034 Zero delay: stage_cycles_i=0. Required: consecutive domains release 1 cycle apart; dom_rst_n_o[0] at E+9.
REQ-035 Mid-sequence re-reset: rst_req_i pulsed 1 cycle just after dom_rst_n_o[1] rises, D=5. Required: dom_rst_n_o=0000 on the next edge with clk_en_o=1; dom_rst_n_o[0] rises 10 cycles after ASSERT entry.
REQ-036 Simultaneous requests: stop_i and rst_req_i both high in DONE. Required: ASSERT taken and clk_en_o stays 1.
REQ-037 Shutdown: stop_i=1 in DONE. Required: resets go 0 on the next edge, clk_en_o falls 2 cycles later, busy_o=0 in IDLE. Also: stop_i during RELEASE has no effect.
REQ-038 Reset mid-operation: rst_n_i=0 in RELEASE stage 2. Required: all outputs at reset values on that edge; a following start_i repeats the REQ-033 timing exactly.
